// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with wrap-bit pointers, threshold flags,
// sticky overflow/underflow flags, synchronous flush and optional
// first-word-fall-through read mode.
module param_sync_fifo #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned FIFO_DEPTH         = 8,
  parameter int unsigned SIZE_BITS          = 3,
  parameter int unsigned ALMOST_FULL_LEVEL  = 6,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 2,
  parameter int unsigned FWFT               = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic                  flush,
  input  logic                  clear_errors,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [SIZE_BITS:0]    fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PtrW = SIZE_BITS + 1;
  localparam logic [PtrW-1:0] AfLevel = PtrW'(ALMOST_FULL_LEVEL);
  localparam logic [PtrW-1:0] AeLevel = PtrW'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  q_valid_q, q_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full, empty;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] head;

  // Status decode from registered pointers only.
  always_comb begin
    empty      = (wptr_q == rptr_q);
    full       = (wptr_q[SIZE_BITS-1:0] == rptr_q[SIZE_BITS-1:0]) &&
                 (wptr_q[SIZE_BITS] != rptr_q[SIZE_BITS]);
    fill_count = wptr_q - rptr_q;
    fifo_empty = empty;
    fifo_full  = full;
    almost_full  = (fill_count >= AfLevel);
    almost_empty = (fill_count <= AeLevel);
    head       = mem_q[rptr_q[SIZE_BITS-1:0]];
  end

  // Accept decisions; flush overrides any traffic in its cycle.
  always_comb begin
    wr_accept = write_enable && !full && !flush;
    rd_accept = read_enable && !empty && !flush;
  end

  // Pointer next state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_accept) wptr_d = wptr_q + PtrW'(1);
      if (rd_accept) rptr_d = rptr_q + PtrW'(1);
    end
  end

  // Sticky error flags: a set event beats clear_errors; flush leaves them alone.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear_errors) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (write_enable && full && !flush)  overflow_d  = 1'b1;
    if (read_enable && empty && !flush) underflow_d = 1'b1;
  end

  // Read data path. In FWFT mode q_q remembers the last head shown so q holds
  // its value once the FIFO drains or is flushed.
  always_comb begin
    q_d       = q_q;
    q_valid_d = 1'b0;
    if (FWFT != 0) begin
      if (!empty) q_d = head;
    end else begin
      q_valid_d = rd_accept;
      if (rd_accept) q_d = head;
    end
  end

  // Output selection between registered-read and fall-through modes.
  always_comb begin
    if (FWFT != 0) begin
      q       = empty ? q_q : head;
      q_valid = !empty;
    end else begin
      q       = q_q;
      q_valid = q_valid_q;
    end
    overflow  = overflow_q;
    underflow = underflow_q;
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_accept) mem_q[wptr_q[SIZE_BITS-1:0]] <= data;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: one registered-read instance and one
// first-word-fall-through instance sharing clock and reset.
module tb_param_sync_fifo;

  logic        clock;
  logic        reset;

  logic [31:0] data;
  logic        write_enable, read_enable, flush, clear_errors;
  logic [31:0] q;
  logic        q_valid, fifo_full, fifo_empty, almost_full, almost_empty;
  logic [3:0]  fill_count;
  logic        overflow, underflow;

  logic [31:0] data_f;
  logic        write_enable_f, read_enable_f;
  logic [31:0] q_f;
  logic        q_valid_f, fifo_full_f, fifo_empty_f, almost_full_f, almost_empty_f;
  logic [3:0]  fill_count_f;
  logic        overflow_f, underflow_f;

  int compared;
  int mismatched;

  param_sync_fifo #(.FWFT(0)) dut (
    .clock        (clock),
    .reset        (reset),
    .data         (data),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .flush        (flush),
    .clear_errors (clear_errors),
    .q            (q),
    .q_valid      (q_valid),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fill_count   (fill_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  param_sync_fifo #(.FWFT(1)) dut_f (
    .clock        (clock),
    .reset        (reset),
    .data         (data_f),
    .write_enable (write_enable_f),
    .read_enable  (read_enable_f),
    .flush        (1'b0),
    .clear_errors (1'b0),
    .q            (q_f),
    .q_valid      (q_valid_f),
    .fifo_full    (fifo_full_f),
    .fifo_empty   (fifo_empty_f),
    .almost_full  (almost_full_f),
    .almost_empty (almost_empty_f),
    .fill_count   (fill_count_f),
    .overflow     (overflow_f),
    .underflow    (underflow_f)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " fill_count"},   32'(fill_count), 32'd0);
    check({tag, " fifo_empty"},   32'(fifo_empty), 32'd1);
    check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
    check({tag, " fifo_full"},    32'(fifo_full), 32'd0);
    check({tag, " almost_full"},  32'(almost_full), 32'd0);
    check({tag, " q"},            q, 32'd0);
    check({tag, " q_valid"},      32'(q_valid), 32'd0);
    check({tag, " overflow"},     32'(overflow), 32'd0);
    check({tag, " underflow"},    32'(underflow), 32'd0);
    check({tag, " f q"},          q_f, 32'd0);
    check({tag, " f q_valid"},    32'(q_valid_f), 32'd0);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b0;
    data = '0; write_enable = 0; read_enable = 0; flush = 0; clear_errors = 0;
    data_f = '0; write_enable_f = 0; read_enable_f = 0;

    #3;
    check_reset_state("reset");
    @(negedge clock);
    reset = 1'b1;

    // FWFT instance: word falls through with no read request.
    data_f = 32'hA5; write_enable_f = 1;
    tick();
    write_enable_f = 0;
    tick();
    check("fwft q head", q_f, 32'hA5);
    check("fwft q_valid", 32'(q_valid_f), 32'd1);
    data_f = 32'hB6; write_enable_f = 1;
    tick();
    write_enable_f = 0; read_enable_f = 1;
    tick();
    check("fwft q next", q_f, 32'hB6);
    check("fwft fill", 32'(fill_count_f), 32'd1);
    tick();
    read_enable_f = 0;
    check("fwft drained valid", 32'(q_valid_f), 32'd0);
    check("fwft drained q holds", q_f, 32'hB6);

    // Fill the registered-read instance with 1..8.
    for (int i = 1; i <= 8; i++) begin
      data = 32'(i); write_enable = 1;
      tick();
      check($sformatf("fill count %0d", i), 32'(fill_count), 32'(i));
      check($sformatf("fill af %0d", i), 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
      check($sformatf("fill ae %0d", i), 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
    end
    check("full flag", 32'(fifo_full), 32'd1);
    check("full overflow clear", 32'(overflow), 32'd0);
    data = 32'h99;
    tick();
    write_enable = 0;
    check("overflow set", 32'(overflow), 32'd1);
    check("overflow count", 32'(fill_count), 32'd8);

    // Drain: each word appears one cycle after its request.
    read_enable = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("read q %0d", i), q, 32'(i));
      check($sformatf("read valid %0d", i), 32'(q_valid), 32'd1);
    end
    read_enable = 0;
    tick();
    check("drain valid low", 32'(q_valid), 32'd0);
    check("drain q holds", q, 32'd8);
    check("drain empty", 32'(fifo_empty), 32'd1);
    read_enable = 1;
    tick();
    read_enable = 0;
    check("underflow set", 32'(underflow), 32'd1);
    check("underflow no valid", 32'(q_valid), 32'd0);
    clear_errors = 1;
    tick();
    clear_errors = 0;
    check("clear overflow", 32'(overflow), 32'd0);
    check("clear underflow", 32'(underflow), 32'd0);

    // Fill to 4 then stream across the pointer wrap.
    write_enable = 1;
    for (int i = 0; i < 4; i++) begin
      data = 32'h10 + 32'(i);
      tick();
    end
    check("stream prefill", 32'(fill_count), 32'd4);
    read_enable = 1;
    for (int i = 0; i < 20; i++) begin
      data = 32'h14 + 32'(i);
      tick();
      check($sformatf("stream q %0d", i), q, 32'h10 + 32'(i));
      check($sformatf("stream fill %0d", i), 32'(fill_count), 32'd4);
    end
    read_enable = 0;

    // Top up to full, then read+write while full: read wins.
    for (int i = 0; i < 4; i++) begin
      data = 32'h28 + 32'(i);
      tick();
    end
    check("refill full", 32'(fifo_full), 32'd1);
    data = 32'hFF; read_enable = 1;
    tick();
    write_enable = 0; read_enable = 0;
    check("full rw q", q, 32'h24);
    check("full rw fill", 32'(fill_count), 32'd7);
    check("full rw overflow", 32'(overflow), 32'd1);
    clear_errors = 1;
    tick();
    clear_errors = 0;
    check("full rw clear", 32'(overflow), 32'd0);

    // Down to 5, then flush with a competing read.
    read_enable = 1;
    tick();
    tick();
    check("pre-flush q", q, 32'h26);
    check("pre-flush fill", 32'(fill_count), 32'd5);
    flush = 1;
    tick();
    flush = 0; read_enable = 0;
    check("flush empty", 32'(fifo_empty), 32'd1);
    check("flush fill", 32'(fill_count), 32'd0);
    check("flush valid", 32'(q_valid), 32'd0);
    check("flush q holds", q, 32'h26);
    data = 32'h77; write_enable = 1;
    tick();
    write_enable = 0; read_enable = 1;
    tick();
    read_enable = 0;
    check("post-flush q", q, 32'h77);

    // Asynchronous reset in the middle of a write burst.
    write_enable = 1; data = 32'h31;
    tick();
    data = 32'h32;
    tick();
    check("burst fill", 32'(fill_count), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    write_enable = 0;
    @(negedge clock);
    reset = 1'b1;
    data = 32'h55; write_enable = 1;
    tick();
    write_enable = 0;
    check("post-reset fill", 32'(fill_count), 32'd1);
    read_enable = 1;
    tick();
    read_enable = 0;
    check("post-reset q", q, 32'h55);
    check("post-reset valid", 32'(q_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
